// File: rtl/spawn_scheduler.sv
// spawn_scheduler: frame-paced object spawn scheduler with round-robin slot pick and req/ack handoff.
// Optional build macro DIFFICULTY_RAMP_EN shortens the reload gap as score_counter rises.
module spawn_scheduler #(
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned MIN_GAP       = 30,
    parameter int unsigned GAP_RAND_BITS = 6,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         start_of_frame,
    input  logic                         enable,
    input  logic [7:0]                   random_number,
    input  logic [NUM_SLOTS-1:0]         slot_busy,
    input  logic [7:0]                   score_counter,
    input  logic                         spawn_ack,
    output logic                         spawn_req,
    output logic [2:0]                   spawn_type,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
    output logic [7:0]                   spawn_count
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned GAP_W  = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_REQ} state_t;

    state_t            r_state, w_state_nxt;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_nxt;
    logic [7:0]        r_tmo, w_tmo_nxt;
    logic [SLOT_W-1:0] r_rr_ptr, w_rr_nxt;
    logic              r_req, w_req_nxt;
    logic [2:0]        r_type, w_type_nxt;
    logic [SLOT_W-1:0] r_slot, w_slot_nxt;
    logic [7:0]        r_count, w_count_nxt;

    logic [GAP_W-1:0]  w_min_gap_eff;
    logic [GAP_W-1:0]  w_reload;
    logic              w_found;
    logic [SLOT_W-1:0] w_free_slot;
    logic [2:0]        w_type_sel;
    logic              w_tmo_done;

`ifdef DIFFICULTY_RAMP_EN
    always_comb begin : ramp_gap
        int v_gap;
        v_gap         = int'(MIN_GAP) - 2 * int'(score_counter[7:4]);
        w_min_gap_eff = (v_gap < 8) ? GAP_W'(8) : GAP_W'(v_gap);
    end
`else
    logic w_unused_score;
    assign w_unused_score = ^score_counter;
    assign w_min_gap_eff  = GAP_W'(MIN_GAP);
`endif

    assign w_reload   = w_min_gap_eff + GAP_W'(random_number[GAP_RAND_BITS-1:0]);
    assign w_tmo_done = (r_tmo == 8'(ACK_TIMEOUT - 1));

    always_comb begin
        case (random_number[7:5])
            3'd0:                w_type_sel = 3'd1;
            3'd1, 3'd2, 3'd3:    w_type_sel = 3'd2;
            3'd4, 3'd5:          w_type_sel = 3'd3;
            default:             w_type_sel = 3'd4;
        endcase
    end

    // Search starts one past the last accepted slot and wraps modulo NUM_SLOTS.
    always_comb begin : slot_search
        logic [SLOT_W:0] v_idx;
        v_idx       = '0;
        w_found     = 1'b0;
        w_free_slot = '0;
        for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (SLOT_W+1)'(k);
            if (v_idx >= (SLOT_W+1)'(NUM_SLOTS)) v_idx = v_idx - (SLOT_W+1)'(NUM_SLOTS);
            if (!w_found && !slot_busy[v_idx[SLOT_W-1:0]]) begin
                w_found     = 1'b1;
                w_free_slot = v_idx[SLOT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start_of_frame && (r_gap_cnt == '0)) w_state_nxt = ST_SELECT;
                ST_SELECT: w_state_nxt = w_found ? ST_REQ : ST_IDLE;
                ST_REQ:    if (spawn_ack || w_tmo_done) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Disable wins over everything: request drops, gap and pointer are frozen.
    always_comb begin
        w_gap_nxt   = r_gap_cnt;
        w_tmo_nxt   = r_tmo;
        w_rr_nxt    = r_rr_ptr;
        w_req_nxt   = r_req;
        w_type_nxt  = r_type;
        w_slot_nxt  = r_slot;
        w_count_nxt = r_count;
        if (!enable) begin
            w_req_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_of_frame && (r_gap_cnt != '0)) w_gap_nxt = r_gap_cnt - 1'b1;
                end
                ST_SELECT: begin
                    if (w_found) begin
                        w_type_nxt = w_type_sel;
                        w_slot_nxt = w_free_slot;
                        w_req_nxt  = 1'b1;
                        w_tmo_nxt  = '0;
                    end else begin
                        w_gap_nxt = '0;
                    end
                end
                ST_REQ: begin
                    if (spawn_ack) begin
                        w_req_nxt   = 1'b0;
                        w_count_nxt = r_count + 1'b1;
                        w_rr_nxt    = r_slot;
                        w_gap_nxt   = w_reload;
                    end else if (w_tmo_done) begin
                        w_req_nxt = 1'b0;
                        w_gap_nxt = w_reload;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_gap_cnt <= GAP_W'(MIN_GAP);
            r_tmo     <= '0;
            r_rr_ptr  <= SLOT_W'(NUM_SLOTS - 1);
            r_req     <= 1'b0;
            r_type    <= '0;
            r_slot    <= '0;
            r_count   <= '0;
        end else begin
            r_gap_cnt <= w_gap_nxt;
            r_tmo     <= w_tmo_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_req     <= w_req_nxt;
            r_type    <= w_type_nxt;
            r_slot    <= w_slot_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign spawn_req   = r_req;
    assign spawn_type  = r_type;
    assign spawn_slot  = r_slot;
    assign spawn_count = r_count;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed bench for spawn_scheduler with a frame-level reference model.
// Expected reload lengths follow DIFFICULTY_RAMP_EN when the bench is built with it.
module tb_spawn_scheduler;

    localparam int NS = 4;
    localparam int MG = 30;
    localparam int AT = 255;

    logic          clk            = 1'b0;
    logic          resetN         = 1'b0;
    logic          start_of_frame = 1'b0;
    logic          enable         = 1'b1;
    logic [7:0]    random_number  = 8'h00;
    logic [NS-1:0] slot_busy      = '0;
    logic [7:0]    score_counter  = 8'h00;
    logic          spawn_ack      = 1'b0;
    logic          spawn_req;
    logic [2:0]    spawn_type;
    logic [1:0]    spawn_slot;
    logic [7:0]    spawn_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spawn_scheduler #(
        .NUM_SLOTS     (NS),
        .MIN_GAP       (MG),
        .GAP_RAND_BITS (6),
        .ACK_TIMEOUT   (AT)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .start_of_frame (start_of_frame),
        .enable         (enable),
        .random_number  (random_number),
        .slot_busy      (slot_busy),
        .score_counter  (score_counter),
        .spawn_ack      (spawn_ack),
        .spawn_req      (spawn_req),
        .spawn_type     (spawn_type),
        .spawn_slot     (spawn_slot),
        .spawn_count    (spawn_count)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frames left before the next attempt, pending request and its age in clocks.
    bit m_sel = 0;
    bit m_req = 0;
    int m_gap = MG;
    int m_ptr = NS - 1;
    int m_hi  = 0;
    int m_type = 0;
    int m_slot = 0;
    int m_cnt  = 0;

    function automatic int gap_after_spawn();
        int e;
`ifdef DIFFICULTY_RAMP_EN
        e = MG - 2 * (int'(score_counter) / 16);
        if (e < 8) e = 8;
`else
        e = MG;
`endif
        return e + int'(random_number) % 64;
    endfunction

    always @(posedge clk or negedge resetN) begin : model
        int  s;
        bit  found;
        int  pick;
        if (!resetN) begin
            m_sel <= 0; m_req <= 0; m_gap <= MG; m_ptr <= NS - 1;
            m_hi <= 0; m_type <= 0; m_slot <= 0; m_cnt <= 0;
        end else if (!enable) begin
            m_sel <= 0;
            m_req <= 0;
        end else if (m_sel) begin
            m_sel <= 0;
            if (random_number < 8'h20)      m_type <= 1;
            else if (random_number < 8'h80) m_type <= 2;
            else if (random_number < 8'hC0) m_type <= 3;
            else                            m_type <= 4;
            found = 0;
            pick  = 0;
            for (int k = 1; k <= NS; k++) begin
                s = (m_ptr + k) % NS;
                if (!found && !slot_busy[s]) begin found = 1; pick = s; end
            end
            if (found) begin m_req <= 1; m_hi <= 1; m_slot <= pick; end
            else       m_gap <= 0;
        end else if (m_req) begin
            if (spawn_ack) begin
                m_req <= 0;
                m_cnt <= (m_cnt + 1) % 256;
                m_ptr <= m_slot;
                m_gap <= gap_after_spawn();
            end else if (m_hi == AT) begin
                m_req <= 0;
                m_gap <= gap_after_spawn();
            end else begin
                m_hi <= m_hi + 1;
            end
        end else if (start_of_frame) begin
            if (m_gap == 0) m_sel <= 1;
            else            m_gap <= m_gap - 1;
        end
    end

    always @(negedge clk) begin
        if (resetN === 1'b1) begin
            check("model_req", int'(spawn_req), int'(m_req));
            check("model_count", int'(spawn_count), m_cnt);
            if (m_req) begin
                check("model_type", int'(spawn_type), m_type);
                check("model_slot", int'(spawn_slot), m_slot);
            end
        end
    end

    // One frame pulse, then wait until the request (if any) would be visible.
    task automatic frames_until_req(input int max, output int n);
        n = 0;
        for (int i = 1; i <= max && n == 0; i++) begin
            @(negedge clk) start_of_frame = 1'b1;
            @(negedge clk) start_of_frame = 1'b0;
            @(negedge clk);
            if (spawn_req) n = i;
        end
    endtask

    task automatic do_ack();
        @(negedge clk) spawn_ack = 1'b1;
        @(negedge clk) spawn_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int hi;
        int exp_types[8];
        logic [7:0] sweep[8];
        sweep     = '{8'h00, 8'h1F, 8'h20, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF};
        exp_types = '{1, 1, 2, 2, 3, 3, 4, 4};

        repeat (3) @(negedge clk);
        resetN = 1'b1;

        // Idle after reset, stray ack ignored
        check("reset_req", int'(spawn_req), 0);
        check("reset_type", int'(spawn_type), 0);
        check("reset_slot", int'(spawn_slot), 0);
        check("reset_count", int'(spawn_count), 0);
        do_ack();
        repeat (20) @(negedge clk);
        check("idle_req", int'(spawn_req), 0);
        check("idle_count", int'(spawn_count), 0);

        // First spawn on the 31st frame
        random_number = 8'h20;
        frames_until_req(40, n);
        check("first_attempt_frame", n, 31);
        check("first_type", int'(spawn_type), 2);
        check("first_slot", int'(spawn_slot), 0);
        do_ack();
        check("ack_req_low", int'(spawn_req), 0);
        check("ack_count", int'(spawn_count), 1);

        // Reload 30+32 = 62: attempt on frame 63 finds no free slot
        slot_busy = 4'b1111;
        frames_until_req(63, n);
        check("all_busy_no_req", n, 0);
        slot_busy = 4'b1011;
        frames_until_req(3, n);
        check("retry_frame", n, 1);
        check("retry_slot", int'(spawn_slot), 2);
        check("retry_type", int'(spawn_type), 2);

        // Unacked request times out after 255 clocks
        random_number = 8'h00;
        slot_busy     = 4'b0000;
        hi = 0;
        while (spawn_req && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        check("timeout_high_clocks", hi, 255);
        check("timeout_count", int'(spawn_count), 1);
        frames_until_req(40, n);
        check("after_timeout_frame", n, 31);
        check("after_timeout_slot", int'(spawn_slot), 1);
        check("after_timeout_type", int'(spawn_type), 1);

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("async_reset_req", int'(spawn_req), 0);
        check("async_reset_count", int'(spawn_count), 0);
        check("async_reset_slot", int'(spawn_slot), 0);
        @(negedge clk) resetN = 1'b1;

        // Four acked spawns walk the slots in order
        for (int i = 0; i < 4; i++) begin
            frames_until_req(40, n);
            check("rr_frame", n, 31);
            check("rr_slot", int'(spawn_slot), i);
            do_ack();
            check("rr_count", int'(spawn_count), i + 1);
        end

        // Disable mid-request: req drops, gap (0) and pointer frozen
        frames_until_req(40, n);
        check("fifth_frame", n, 31);
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check("disable_req_low", int'(spawn_req), 0);
        start_of_frame = 1'b1;
        @(negedge clk) start_of_frame = 1'b0;
        repeat (2) @(negedge clk);
        check("disabled_frame_ignored", int'(spawn_req), 0);
        enable = 1'b1;
        frames_until_req(5, n);
        check("reenable_frame", n, 1);
        check("reenable_slot", int'(spawn_slot), 0);

        // Type decode boundaries, reusing the zero gap after each disable
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) enable = 1'b0;
            @(negedge clk) enable = 1'b1;
            random_number = sweep[i];
            frames_until_req(3, n);
            check("sweep_frame", n, 1);
            check("sweep_type", int'(spawn_type), exp_types[i]);
        end

        // Reload length with high score
        random_number = 8'h00;
        score_counter = 8'hF0;
        do_ack();
        check("score_count", int'(spawn_count), 5);
        frames_until_req(80, n);
`ifdef DIFFICULTY_RAMP_EN
        check("score_gap_frame", n, 9);
`else
        check("score_gap_frame", n, 31);
`endif
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
